// File: rtl/sr_latch_exerciser.sv
// Self-test engine for a gated SR latch. It drives a fixed six-step s/r/enable sequence
// and checks q/q_n after a settle window, then reports pass, the first failing step and a failure count.
module sr_latch_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter bit          STOP_ON_FAIL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       q,
    input  logic       q_n,
    output logic       s,
    output logic       r,
    output logic       enable,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_step,
    output logic [2:0] fail_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_STEP   = 3'd5;

    // Step ROM drive values as {s, r, enable}; s=r=1 with enable=1 never appears.
    function automatic logic [2:0] step_drive(input logic [2:0] idx);
        case (idx)
            3'd0:    step_drive = 3'b011;
            3'd1:    step_drive = 3'b001;
            3'd2:    step_drive = 3'b101;
            3'd3:    step_drive = 3'b001;
            3'd4:    step_drive = 3'b010;
            3'd5:    step_drive = 3'b011;
            default: step_drive = 3'b000;
        endcase
    endfunction

    function automatic logic step_expect(input logic [2:0] idx);
        case (idx)
            3'd2, 3'd3, 3'd4: step_expect = 1'b1;
            default:          step_expect = 1'b0;
        endcase
    endfunction

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_step;
    logic [7:0] r_cnt;
    logic       r_s;
    logic       r_r;
    logic       r_en;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_fail_step;
    logic [2:0] r_fail_count;
    logic [2:0] w_load_idx;
    logic [2:0] w_load;
    logic       w_exp;
    logic       w_mismatch;

    assign w_load_idx = (r_state == ST_IDLE) ? 3'd0 : (r_step + 3'd1);
    assign w_load     = step_drive(w_load_idx);
    assign w_exp      = step_expect(r_step);
    // Case inequality so that X or Z on either latch output counts as a failure.
    assign w_mismatch = (r_state == ST_CHECK) && ((q !== w_exp) || (q_n !== ~w_exp));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_APPLY;
                else       w_next = ST_IDLE;
            end
            ST_APPLY: w_next = ST_SETTLE;
            ST_SETTLE: begin
                if (r_cnt == 8'd0) w_next = ST_CHECK;
                else               w_next = ST_SETTLE;
            end
            ST_CHECK: begin
                if (w_mismatch && STOP_ON_FAIL) w_next = ST_FINISH;
                else if (r_step < LAST_STEP)    w_next = ST_APPLY;
                else                            w_next = ST_FINISH;
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Registered outputs and run datapath, all keyed off the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step       <= 3'd0;
            r_cnt        <= 8'd0;
            r_s          <= 1'b0;
            r_r          <= 1'b0;
            r_en         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_step  <= 3'd0;
            r_fail_count <= 3'd0;
        end else begin
            r_done <= (w_next == ST_FINISH);
            r_busy <= (w_next == ST_APPLY) || (w_next == ST_SETTLE) || (w_next == ST_CHECK);
            if (w_next == ST_APPLY) begin
                {r_s, r_r, r_en} <= w_load;
                r_step           <= w_load_idx;
                r_cnt            <= SETTLE_LOAD;
            end else if ((r_state == ST_SETTLE) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end else if (w_next == ST_FINISH) begin
                {r_s, r_r, r_en} <= 3'b000;
                // The mismatch seen on this same edge must count toward the result.
                r_pass           <= (r_fail_count == 3'd0) && !w_mismatch;
            end else begin
                r_cnt <= r_cnt;
            end
            if ((r_state == ST_IDLE) && start) begin
                r_fail_count <= 3'd0;
                r_fail_step  <= 3'd0;
                r_pass       <= 1'b0;
            end else if (w_mismatch) begin
                r_fail_count <= r_fail_count + 3'd1;
                if (r_fail_count == 3'd0) r_fail_step <= r_step;
                else                      r_fail_step <= r_fail_step;
            end else begin
                r_fail_count <= r_fail_count;
            end
        end
    end

    assign s          = r_s;
    assign r          = r_r;
    assign enable     = r_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_step  = r_fail_step;
    assign fail_count = r_fail_count;

endmodule

// File: tb/tb_sr_latch_exerciser.sv
// Directed bench: three exerciser instances (settle 4/stop, settle 4/run-all, settle 1/stop)
// each driving a behavioural gated SR latch model with selectable faults.
module tb_sr_latch_exerciser;

    localparam int M_IDEAL  = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_NOEN   = 2;
    localparam int M_QNTIED = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] s_v, r_v, en_v, busy_v, done_v, pass_v, q_v, qn_v, lq;
    logic [2:0] fs_v [3];
    logic [2:0] fc_v [3];
    int         mode [3];

    int         errors = 0;
    int         checks = 0;
    int         m_busy, m_done_cnt, m_done_at, tr_n;
    logic       m_to;
    logic [2:0] tr [8];

    always #5 clk = ~clk;

    sr_latch_exerciser #(.SETTLE_CYCLES(4), .STOP_ON_FAIL(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .q(q_v[0]), .q_n(qn_v[0]),
        .s(s_v[0]), .r(r_v[0]), .enable(en_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .fail_step(fs_v[0]), .fail_count(fc_v[0]));
    sr_latch_exerciser #(.SETTLE_CYCLES(4), .STOP_ON_FAIL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .q(q_v[1]), .q_n(qn_v[1]),
        .s(s_v[1]), .r(r_v[1]), .enable(en_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .fail_step(fs_v[1]), .fail_count(fc_v[1]));
    sr_latch_exerciser #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .q(q_v[2]), .q_n(qn_v[2]),
        .s(s_v[2]), .r(r_v[2]), .enable(en_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .fail_step(fs_v[2]), .fail_count(fc_v[2]));

    // Latch models; the no-enable fault lets s/r act while the gate is closed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lq <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s_v[i] && (en_v[i] || mode[i] == M_NOEN))      lq[i] <= 1'b1;
                else if (r_v[i] && (en_v[i] || mode[i] == M_NOEN)) lq[i] <= 1'b0;
            end
        end
    end

    always @* begin
        for (int i = 0; i < 3; i++) begin
            q_v[i]  = (mode[i] == M_STUCK0) ? 1'b0 : lq[i];
            qn_v[i] = (mode[i] == M_QNTIED) ? q_v[i] : ~q_v[i];
        end
    end

    // Launches one run on instance d and records busy length, done timing and the s/r/enable trace.
    task automatic do_run(input int d, input int pulse_at);
        logic [2:0] prev;
        int n;
        m_busy = 0; m_done_cnt = 0; m_done_at = 0; tr_n = 0; prev = 3'b000;
        @(negedge clk);
        start_v[d] = 1'b1;
        n = 0;
        while (n < 200 && !(m_done_cnt > 0 && n >= m_done_at + 4)) begin
            @(negedge clk);
            n++;
            if (n == 1) start_v[d] = 1'b0;
            if (n == pulse_at) start_v[d] = 1'b1;
            if (n == pulse_at + 1) start_v[d] = 1'b0;
            if (busy_v[d]) m_busy++;
            if ({s_v[d], r_v[d], en_v[d]} != prev) begin
                if (tr_n < 8) tr[tr_n] = {s_v[d], r_v[d], en_v[d]};
                tr_n++;
                prev = {s_v[d], r_v[d], en_v[d]};
            end
            if (done_v[d]) begin
                m_done_cnt++;
                if (m_done_cnt == 1) m_done_at = n;
            end
        end
        m_to = (m_done_cnt == 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_v = 3'b000;
        for (int i = 0; i < 3; i++) mode[i] = M_IDEAL;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({s_v[i], r_v[i], en_v[i], busy_v[i], done_v[i], pass_v[i]} !== 6'b000000) begin
                errors++; $display("FAIL reset_ctrl[%0d]: got %b want 000000", i,
                    {s_v[i], r_v[i], en_v[i], busy_v[i], done_v[i], pass_v[i]});
            end
            checks++;
            if ({fs_v[i], fc_v[i]} !== 6'd0) begin
                errors++; $display("FAIL reset_fail_regs[%0d]: got %b want 000000", i, {fs_v[i], fc_v[i]});
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pass_run();
        logic [2:0] exp_tr [7];
        exp_tr = '{3'b011, 3'b001, 3'b101, 3'b001, 3'b010, 3'b011, 3'b000};
        do_run(0, 0);
        checks++; if (m_to !== 1'b0) begin errors++; $display("FAIL pass_timeout: got no done want done"); end
        checks++; if (m_busy !== 36) begin errors++; $display("FAIL pass_busy_len: got %0d want 36", m_busy); end
        checks++; if (m_done_cnt !== 1) begin errors++; $display("FAIL pass_done_cnt: got %0d want 1", m_done_cnt); end
        checks++; if (m_done_at !== 37) begin errors++; $display("FAIL pass_done_at: got %0d want 37", m_done_at); end
        checks++; if (pass_v[0] !== 1'b1) begin errors++; $display("FAIL pass_flag: got %b want 1", pass_v[0]); end
        checks++; if (fs_v[0] !== 3'd0) begin errors++; $display("FAIL pass_fail_step: got %0d want 0", fs_v[0]); end
        checks++; if (fc_v[0] !== 3'd0) begin errors++; $display("FAIL pass_fail_count: got %0d want 0", fc_v[0]); end
        checks++; if (tr_n !== 7) begin errors++; $display("FAIL pass_trace_len: got %0d want 7", tr_n); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (tr[i] !== exp_tr[i]) begin errors++; $display("FAIL pass_trace[%0d]: got %b want %b", i, tr[i], exp_tr[i]); end
        end
    endtask

    task automatic test_stop_on_fail();
        mode[0] = M_STUCK0;
        do_run(0, 0);
        checks++; if (m_busy !== 18) begin errors++; $display("FAIL stop_busy_len: got %0d want 18", m_busy); end
        checks++; if (m_done_at !== 19) begin errors++; $display("FAIL stop_done_at: got %0d want 19", m_done_at); end
        checks++; if (pass_v[0] !== 1'b0) begin errors++; $display("FAIL stop_pass: got %b want 0", pass_v[0]); end
        checks++; if (fs_v[0] !== 3'd2) begin errors++; $display("FAIL stop_fail_step: got %0d want 2", fs_v[0]); end
        checks++; if (fc_v[0] !== 3'd1) begin errors++; $display("FAIL stop_fail_count: got %0d want 1", fc_v[0]); end
        mode[0] = M_IDEAL;
    endtask

    task automatic test_run_all();
        mode[1] = M_STUCK0;
        do_run(1, 0);
        checks++; if (m_busy !== 36) begin errors++; $display("FAIL runall_busy_len: got %0d want 36", m_busy); end
        checks++; if (pass_v[1] !== 1'b0) begin errors++; $display("FAIL runall_pass: got %b want 0", pass_v[1]); end
        checks++; if (fs_v[1] !== 3'd2) begin errors++; $display("FAIL runall_fail_step: got %0d want 2", fs_v[1]); end
        checks++; if (fc_v[1] !== 3'd3) begin errors++; $display("FAIL runall_fail_count: got %0d want 3", fc_v[1]); end
    endtask

    task automatic test_ignore_enable();
        mode[1] = M_NOEN;
        do_run(1, 0);
        checks++; if (pass_v[1] !== 1'b0) begin errors++; $display("FAIL noen_pass: got %b want 0", pass_v[1]); end
        checks++; if (fs_v[1] !== 3'd4) begin errors++; $display("FAIL noen_fail_step: got %0d want 4", fs_v[1]); end
        checks++; if (fc_v[1] !== 3'd1) begin errors++; $display("FAIL noen_fail_count: got %0d want 1", fc_v[1]); end
    endtask

    task automatic test_qn_tied();
        mode[1] = M_QNTIED;
        do_run(1, 0);
        checks++; if (m_busy !== 36) begin errors++; $display("FAIL qntied_busy_len: got %0d want 36", m_busy); end
        checks++; if (pass_v[1] !== 1'b0) begin errors++; $display("FAIL qntied_pass: got %b want 0", pass_v[1]); end
        checks++; if (fs_v[1] !== 3'd0) begin errors++; $display("FAIL qntied_fail_step: got %0d want 0", fs_v[1]); end
        checks++; if (fc_v[1] !== 3'd6) begin errors++; $display("FAIL qntied_fail_count: got %0d want 6", fc_v[1]); end
        mode[1] = M_IDEAL;
    endtask

    task automatic test_start_ignored();
        // Step 3 SETTLE occupies observation cycles 20..23 with SETTLE_CYCLES=4.
        do_run(0, 21);
        checks++; if (m_done_cnt !== 1) begin errors++; $display("FAIL ign_done_cnt: got %0d want 1", m_done_cnt); end
        checks++; if (m_done_at !== 37) begin errors++; $display("FAIL ign_done_at: got %0d want 37", m_done_at); end
        checks++; if (m_busy !== 36) begin errors++; $display("FAIL ign_busy_len: got %0d want 36", m_busy); end
        checks++; if (pass_v[0] !== 1'b1) begin errors++; $display("FAIL ign_pass: got %b want 1", pass_v[0]); end
    endtask

    task automatic test_mid_reset();
        int n;
        int dn;
        @(negedge clk);
        start_v[0] = 1'b1;
        n = 0;
        while (n < 9) begin
            @(negedge clk);
            n++;
            if (n == 1) start_v[0] = 1'b0;
        end
        checks++;
        if ({s_v[0], r_v[0], en_v[0], busy_v[0]} !== 4'b0011) begin
            errors++; $display("FAIL mid_pre_reset: got %b want 0011", {s_v[0], r_v[0], en_v[0], busy_v[0]});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_v[0], r_v[0], en_v[0], busy_v[0]} !== 4'b0000) begin
            errors++; $display("FAIL mid_async_clear: got %b want 0000", {s_v[0], r_v[0], en_v[0], busy_v[0]});
        end
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_v[0]) dn++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", dn); end
        do_run(0, 0);
        checks++; if (m_busy !== 36) begin errors++; $display("FAIL mid_rerun_busy: got %0d want 36", m_busy); end
        checks++; if (pass_v[0] !== 1'b1) begin errors++; $display("FAIL mid_rerun_pass: got %b want 1", pass_v[0]); end
    endtask

    task automatic test_short_settle();
        do_run(2, 0);
        checks++; if (m_busy !== 18) begin errors++; $display("FAIL short_busy_len: got %0d want 18", m_busy); end
        checks++; if (m_done_at !== 19) begin errors++; $display("FAIL short_done_at: got %0d want 19", m_done_at); end
        checks++; if (pass_v[2] !== 1'b1) begin errors++; $display("FAIL short_pass: got %b want 1", pass_v[2]); end
        checks++; if (fc_v[2] !== 3'd0) begin errors++; $display("FAIL short_fail_count: got %0d want 0", fc_v[2]); end
        checks++;
        if ({s_v[2], r_v[2], en_v[2]} !== 3'b000) begin
            errors++; $display("FAIL short_final_drive: got %b want 000", {s_v[2], r_v[2], en_v[2]});
        end
    endtask

    initial begin
        test_reset();
        test_pass_run();
        test_stop_on_fail();
        test_run_all();
        test_ignore_enable();
        test_qn_tied();
        test_start_ignored();
        test_mid_reset();
        test_short_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_latch_exerciser.md
Name: sr_latch_exerciser

Overview:
Stimulus-and-check engine for the opposite end of the gated SR latch interface. It drives s/r/enable into a latch instance and samples the latch's q/q_n response against a fixed six-step truth-table sequence. It reports pass/fail, the first failing step and a mismatch count. It sits beside the latch in self-test builds and replaces hand-written benches for on-board checks.

Parameters:
SETTLE_CYCLES, 4, clock cycles s/r/enable are held before q/q_n is sampled (legal range 1..255)
STOP_ON_FAIL, 1, 1 = end the run at the first mismatch; 0 = run all steps

Ports:
clk         input   1  single clock, rising edge
rst_n       input   1  asynchronous active-low reset
start       input   1  level-sampled request to begin a run
q           input   1  latch output under test
q_n         input   1  latch complementary output under test
s           output  1  latch set drive (registered)
r           output  1  latch reset drive (registered)
enable      output  1  latch gate drive (registered)
busy        output  1  high from the first APPLY through the last CHECK
done        output  1  one-cycle pulse at end of run
pass        output  1  run result, valid from done until next start
fail_step   output  3  index of first failing step (0 if none)
fail_count  output  3  number of failing steps in the run

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; s=r=enable=0; busy=done=pass=0; fail_step=fail_count=0. A reset asserted mid-run aborts the run immediately. No done pulse is produced.
- Step ROM, given as index: s r enable -> expected q:
  0: 0 1 1 -> 0 (reset)
  1: 0 0 1 -> 0 (hold)
  2: 1 0 1 -> 1 (set)
  3: 0 0 1 -> 1 (hold)
  4: 0 1 0 -> 1 (gated off, must ignore r)
  5: 0 1 1 -> 0 (reset)
- s=r=1 with enable=1 is never driven.
- FSM states: IDLE, APPLY, SETTLE, CHECK, FINISH.
- IDLE:
  - start=1 sampled -> APPLY with step=0.
  - On this same edge, fail_count, fail_step and pass are cleared.
- APPLY (1 cycle):
  - s/r/enable load ROM[step] on the edge entering APPLY.
  - The settle counter loads SETTLE_CYCLES-1 on that edge.
  - APPLY -> SETTLE.
- SETTLE: the counter decrements each cycle. At 0 -> CHECK. SETTLE therefore lasts SETTLE_CYCLES cycles.
- CHECK (1 cycle): q and q_n are compared on the exit edge.
  - Mismatch if q !== expected or q_n !== ~expected. X or Z on either input counts as a mismatch.
  - On mismatch, fail_count increments. fail_step captures step only if this is the first failure.
  - Next state:
    - Mismatch and STOP_ON_FAIL=1 -> FINISH.
    - Otherwise, step<5 -> APPLY with step+1.
    - Otherwise -> FINISH.
- s/r/enable hold their step values through SETTLE and CHECK. They change only on APPLY entry or FINISH entry.
- FINISH (1 cycle):
  - done=1; pass=(fail_count==0); s=r=enable=0 loaded on entry.
  - FINISH -> IDLE.
- pass holds its value in IDLE.
- busy = state is APPLY, SETTLE or CHECK.
- start while busy or in FINISH is ignored. start held high in IDLE launches back-to-back runs, with one IDLE cycle between runs.
- Timing: a full passing run spans 6*(SETTLE_CYCLES+2) busy cycles. done rises 6*(SETTLE_CYCLES+2)+1 cycles after the edge that samples start.
- fail_count maximum is 6, so 3 bits never overflow.

Test Plan:
1. Ideal gated SR latch model, SETTLE_CYCLES=4, pulse start -> busy high 36 cycles. done pulses once at cycle 37. pass=1, fail_step=0, fail_count=0. s/r/enable step through the ROM and end at 0/0/0.
2. Latch model with q stuck at 0 and q_n=~q, STOP_ON_FAIL=1 -> run ends after step 2 CHECK. done pulses, pass=0, fail_step=2, fail_count=1.
3. Same stuck-at-0 model, STOP_ON_FAIL=0 -> all 6 steps run. Steps 2, 3 and 4 fail. pass=0, fail_step=2, fail_count=3.
4. Model that ignores enable (step 4 clears q) -> pass=0, fail_step=4. Second variant: q_n tied to q -> fail_step=0, fail_count=6 with STOP_ON_FAIL=0.
5. Pulse start again during step 3 SETTLE -> ignored. Exactly one done pulse, with the timing of scenario 1.
6. Assert rst_n low during step 1 SETTLE -> s/r/enable/busy go to 0 immediately, with no done pulse. After release, start -> a clean full run with pass=1. Repeat with SETTLE_CYCLES=1: busy lasts 18 cycles.
